shared_unit_arbiter: RTL

- Shares one elastic (valid/ready) arithmetic unit, e.g. a pipelined float op, between NUM_REQ dataflow requesters.
- Grants issue slots round-robin and records the owner of each issued operand in an order FIFO.
- Steers each result back to its owner's output queue.
- Per-requester credits bound in-flight work, so a stalled consumer can never block the shared unit (no dataflow deadlock).

---
 rtl/shared_unit_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/shared_unit_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/shared_unit_pkg.sv
// Shared definitions for the shared-unit arbiter: width helpers and default sizing.
package shared_unit_pkg;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

    // Index fields are never narrower than one bit, even for a single entry.
    function automatic int idx_width(input int count);
        return (clog2(count) < 1) ? 1 : clog2(count);
    endfunction

    localparam int DEFAULT_NUM_REQ   = 2;
    localparam int DEFAULT_OUT_DEPTH = 2;
    localparam int IDX_W  = idx_width(DEFAULT_NUM_REQ);
    localparam int CRED_W = clog2(DEFAULT_OUT_DEPTH + 1);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a combinational head; push into a full FIFO is accepted
// only when a pop frees the slot in the same cycle.
module sync_fifo
    import shared_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = idx_width(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/shared_unit_arbiter.sv
// Round-robin sharing of one in-order elastic unit between NUM_REQ requesters,
// with per-requester credits so a stalled consumer never blocks the unit.
module shared_unit_arbiter
    import shared_unit_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int BITWIDTH  = 32,
    parameter int OUT_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ*BITWIDTH-1:0]  req_data,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [BITWIDTH-1:0]          unit_ins,
    output logic                         unit_ins_valid,
    input  logic                         unit_ins_ready,
    input  logic [BITWIDTH-1:0]          unit_outs,
    input  logic                         unit_outs_valid,
    output logic                         unit_outs_ready,
    output logic [NUM_REQ*BITWIDTH-1:0]  resp_data,
    output logic [NUM_REQ-1:0]           resp_valid,
    input  logic [NUM_REQ-1:0]           resp_ready
);

    // Handshake rule on every channel: a transfer happens exactly on a rising
    // edge where valid and ready are both 1; valid never depends on ready.

    localparam int SEL_W     = idx_width(NUM_REQ);
    localparam int CNT_W     = clog2(OUT_DEPTH + 1);
    localparam int ORD_DEPTH = NUM_REQ * OUT_DEPTH;

    logic [SEL_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   credit [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [SEL_W:0]     cand;
    logic               grant_valid;
    logic [SEL_W-1:0]   grant_idx;
    logic               issue;
    logic               accept;
    logic               ord_full;
    logic               ord_empty;
    logic [SEL_W-1:0]   ord_head;
    logic [NUM_REQ-1:0] res_push;
    logic [NUM_REQ-1:0] res_pop;
    logic [NUM_REQ-1:0] res_empty;
    logic [NUM_REQ-1:0] res_full;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (credit[i] != '0) && !ord_full;
        end
    end

    // Scan pointer, pointer+1, ... (mod NUM_REQ) and take the first eligible.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (SEL_W + 1)'(k);
            if (cand >= (SEL_W + 1)'(NUM_REQ)) begin
                cand = cand - (SEL_W + 1)'(NUM_REQ);
            end
            if (!grant_valid && eligible[cand[SEL_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        unit_ins  = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_valid && (grant_idx == SEL_W'(i))) begin
                unit_ins     = req_data[i*BITWIDTH +: BITWIDTH];
                req_ready[i] = unit_ins_ready;
            end
        end
    end

    assign unit_ins_valid  = grant_valid;
    assign issue           = grant_valid && unit_ins_ready;
    assign unit_outs_ready = !ord_empty;
    assign accept          = unit_outs_valid && !ord_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (issue) begin
            rr_ptr <= (grant_idx == SEL_W'(NUM_REQ - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
    end

    // req_ready[i] is exactly "requester i issued this cycle".
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst) begin
                credit[i] <= CNT_W'(OUT_DEPTH);
            end else if (req_ready[i] && !res_pop[i]) begin
                credit[i] <= credit[i] - CNT_W'(1);
            end else if (!req_ready[i] && res_pop[i]) begin
                credit[i] <= credit[i] + CNT_W'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (SEL_W),
        .DEPTH (ORD_DEPTH)
    ) u_order_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue),
        .push_data (grant_idx),
        .pop       (accept),
        .pop_data  (ord_head),
        .empty     (ord_empty),
        .full      (ord_full)
    );

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_resp
        assign res_push[i]   = accept && (ord_head == SEL_W'(i));
        assign resp_valid[i] = !res_empty[i];
        assign res_pop[i]    = !res_empty[i] && resp_ready[i];

        sync_fifo #(
            .WIDTH (BITWIDTH),
            .DEPTH (OUT_DEPTH)
        ) u_resp_q (
            .clk       (clk),
            .rst       (rst),
            .push      (res_push[i]),
            .push_data (unit_outs),
            .pop       (res_pop[i]),
            .pop_data  (resp_data[i*BITWIDTH +: BITWIDTH]),
            .empty     (res_empty[i]),
            .full      (res_full[i])
        );

        // Credits reserve a slot for every in-flight result; a full queue here is a design bug.
        overflow_chk: assert property (@(posedge clk) disable iff (!rst)
            !(res_push[i] && res_full[i] && !res_pop[i]));
    end

endmodule
